// File: rtl/alu_mul_seq.sv
// Multiply-by-repeated-addition sequencer driving the shared ALU.
// Alternates ADD (acc + multiplicand) and DEC (cnt - 1) passes until the count reaches zero.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] alu_res,
    output logic [1:0]       sel_srcb,
    output logic [WIDTH-1:0] srca_data,
    output logic [WIDTH-1:0] treg_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam logic [1:0] SEL_INC = 2'b00;
    localparam logic [1:0] SEL_DEC = 2'b01;
    localparam logic [1:0] SEL_REG = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DEC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] treg_q, treg_d;
    logic [1:0]       sel_q;
    logic [WIDTH-1:0] srca_q;
    logic             busy_q;
    logic             done_q;

    // ALU source-B select presented while sitting in a given state.
    function automatic logic [1:0] sel_for(input state_t s);
        logic [1:0] sel;
        case (s)
            ST_ADD:  sel = SEL_REG;
            ST_DEC:  sel = SEL_DEC;
            default: sel = SEL_INC;
        endcase
        return sel;
    endfunction

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        treg_d  = treg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = count_in;
                    treg_d  = mcand_in;
                    state_d = (count_in != {WIDTH{1'b0}}) ? ST_ADD : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                acc_d   = alu_res;
                state_d = ST_DEC;
            end
            ST_DEC: begin
                cnt_d = alu_res;
                if (alu_res == {WIDTH{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and outputs registered together; outputs are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= {WIDTH{1'b0}};
            cnt_q   <= {WIDTH{1'b0}};
            treg_q  <= {WIDTH{1'b0}};
            sel_q   <= SEL_INC;
            srca_q  <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            treg_q  <= treg_d;
            sel_q   <= sel_for(state_d);
            srca_q  <= (state_d == ST_DEC) ? cnt_d : acc_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign sel_srcb  = sel_q;
    assign srca_data = srca_q;
    assign treg_data = treg_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = acc_q;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that performs an unsigned multiply by repeated addition on the shared 8-bit ALU.
- It drives the ALU source-B select and the source-A operand each cycle, and captures the ALU result back into internal accumulator and counter registers.
- Each iteration alternates two ALU passes:
  - ADD pass: accumulator + multiplicand (source-B select = register operand).
  - DEC pass: counter + (-1) (source-B select = constant -1).
- It sits beside the decode/control unit and owns the ALU operand selects while busy.

Parameters:
- WIDTH, 8, datapath width of operands, accumulator, counter and product.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a multiply; sampled only in IDLE.
- mcand_in  input  WIDTH  multiplicand; latched on accepted start.
- count_in  input  WIDTH  multiplier (iteration count); latched on accepted start.
- alu_res  input  WIDTH  combinational ALU result, defined as srca_data + srcB mux output, mod 2^WIDTH.
- sel_srcb  output  2  ALU source-B select encoding:
  - 00 = +1
  - 01 = -1
  - 10 = register operand
  - 11 = immediate
- srca_data  output  WIDTH  ALU source-A operand.
- treg_data  output  WIDTH  latched multiplicand, fed to the source-B register-operand input.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle inclusive.
- done  output  1  one-cycle pulse when product is final.
- product  output  WIDTH  result, i.e. the accumulator register.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE.
  - acc, cnt, treg_data = 0.
  - sel_srcb = 2'b00, srca_data = 0.
  - busy = 0, done = 0, product = 0.
  - Reset mid-operation aborts the multiply; no done pulse is produced.
- States: IDLE, ADD, DEC, DONE. All outputs are decoded from registered state; there is no combinational start-to-output path.
- IDLE:
  - sel_srcb = 00, srca_data = acc, busy = 0.
  - On start=1:
    - acc <= 0, cnt <= count_in, treg_data <= mcand_in.
    - Next state is ADD if count_in != 0, else DONE.
  - start=0: remain in IDLE.
- ADD:
  - sel_srcb = 10, srca_data = acc.
  - acc <= alu_res; next state DEC.
- DEC:
  - sel_srcb = 01, srca_data = cnt.
  - cnt <= alu_res.
  - Next state DONE if alu_res == 0, else ADD.
- DONE:
  - done = 1, busy = 1, sel_srcb = 00, srca_data = acc.
  - Next state IDLE unconditionally.
- Latency: done asserts 2*N+1 cycles after the start-accept edge (N = count_in); for N=0, done asserts on the next cycle.
- start asserted while not in IDLE is ignored (no queuing). start held high continuously re-launches a new multiply in the IDLE cycle after each DONE.
- Arithmetic: product = (mcand_in * count_in) mod 2^WIDTH. Overflow wraps silently with no flag.
- product holds its value after DONE until the next accepted start clears acc.
- mcand_in and count_in may change freely after accept; only the latched copies are used.
- alu_res is consumed only in ADD and DEC; its value in other states is don't-care.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst_n=0 mid-cycle, release, hold start=0 for 5 cycles.
  - Required: all outputs 0, sel_srcb=00, busy=0, no done.
- Basic multiply:
  - Stimulus: start with mcand=5, count=3.
  - Required: sel_srcb sequence 10,01,10,01,10,01,00; done pulses exactly 7 cycles after accept; product=15 and stays 15 until the next start.
- Zero count:
  - Stimulus: start with mcand=9, count=0.
  - Required: done on the next cycle, product=0, sel_srcb never 10.
- Wrap and max count:
  - Stimulus: start with mcand=20, count=13.
  - Required: product = 260 mod 256 = 4, done 27 cycles after accept.
  - Stimulus: count=255, mcand=1.
  - Required: product=255, done 511 cycles after accept.
- Start while busy and back-to-back:
  - Stimulus: pulse start (mcand=7, count=2) during ADD of a 3x4 job.
  - Required: that start is ignored; the 3x4 job gives product=12.
  - Stimulus: hold start high with mcand=2, count=2.
  - Required: a second job launches in the IDLE cycle after DONE; product=4.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during a DEC state of a 6x6 job.
  - Required: immediate return to IDLE with all outputs 0; no done pulse; next job 3x3 gives product=9.
